ps2_key_decoder: RTL

- Upstream input stage for the CPU keyboard path.
- Deserialises PS/2 device frames (ps2_clk/ps2_data) in the cpu_clk domain and checks framing and parity.
- Strips break (F0) and extended (E0) prefixes and maps make codes to 5-bit key values.
- Buffers keys in a small FIFO with a valid/ready pop handshake, consumed by the keyboard cache / MemOrIO read path.

---
 rtl/ps2_pkg.sv | 54 +++++
 rtl/ps2_key_fifo.sv | 58 +++++
 rtl/ps2_key_decoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard input stage: receive FSM
// states, prefix scancodes, special key values and the scancode-to-key map.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_PARITY  = 3'd2,
    ST_STOP    = 3'd3,
    ST_PROCESS = 3'd4
  } ps2_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [4:0] KEY_ENTER = 5'h10;
  localparam logic [4:0] KEY_BKSP  = 5'h11;
  localparam int         NUM_KEYS  = 18;

  typedef struct packed {
    logic       hit;
    logic [4:0] key;
  } key_lookup_t;

  // Set-2 make codes for the hex keypad subset plus Enter and Backspace.
  function automatic key_lookup_t scancode_to_key(input logic [7:0] sc);
    key_lookup_t r;
    r.hit = 1'b1;
    r.key = 5'h00;
    case (sc)
      8'h45:   r.key = 5'h00;
      8'h16:   r.key = 5'h01;
      8'h1E:   r.key = 5'h02;
      8'h26:   r.key = 5'h03;
      8'h25:   r.key = 5'h04;
      8'h2E:   r.key = 5'h05;
      8'h36:   r.key = 5'h06;
      8'h3D:   r.key = 5'h07;
      8'h3E:   r.key = 5'h08;
      8'h46:   r.key = 5'h09;
      8'h1C:   r.key = 5'h0A;
      8'h32:   r.key = 5'h0B;
      8'h21:   r.key = 5'h0C;
      8'h23:   r.key = 5'h0D;
      8'h24:   r.key = 5'h0E;
      8'h2B:   r.key = 5'h0F;
      8'h5A:   r.key = KEY_ENTER;
      8'h66:   r.key = KEY_BKSP;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Small synchronous key FIFO: pointer pair with an extra wrap bit, head always
// visible (zero when empty), sticky overflow on a dropped push.
module ps2_key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  logic [4:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [4:0] head_o,
  output logic       overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        do_push, do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o     = empty_o ? 5'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o = overflow_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !do_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 5'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronise, deframe, strip F0/E0 prefixes, map to
// 5-bit keys and queue them. PS2_TYPEMATIC_FILTER_EN suppresses held-key repeats.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16384,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_ready,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       frame_err,
  output logic       overflow,
  output logic [2:0] dbg_state_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s, ps2_data_s, fall;

  ps2_state_e  state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic        par_err_q;
  logic [TW-1:0] idle_cnt_q;
  logic        frame_err_q;
  logic        brk_q, ext_q;
  logic        timeout_hit, is_prefix, push;
  key_lookup_t lk;
  logic        fifo_full, fifo_empty;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [NUM_KEYS-1:0] held_q;
`endif

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q && !ps2_clk_s;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= (clk_sync_q << 1) | SYNC_STAGES'(ps2_clk);
      data_sync_q <= (data_sync_q << 1) | SYNC_STAGES'(ps2_data);
      clk_prev_q  <= ps2_clk_s;
    end
  end

  // The watchdog only runs while a frame is being shifted in.
  assign timeout_hit = (state_q inside {ST_DATA, ST_PARITY, ST_STOP}) &&
                       !fall && (idle_cnt_q == TIMEOUT_LAST);

  assign lk        = scancode_to_key(shift_q);
  assign is_prefix = (shift_q == SC_BREAK) || (shift_q == SC_EXT);

  always_comb begin
    push = (state_q == ST_PROCESS) && !is_prefix && !brk_q && !ext_q && lk.hit;
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (held_q[lk.key]) push = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      par_err_q   <= 1'b0;
      idle_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_q      <= '0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      if (fall || state_q == ST_IDLE) idle_cnt_q <= '0;
      else                            idle_cnt_q <= idle_cnt_q + 1'b1;

      if (timeout_hit) begin
        frame_err_q <= 1'b1;
        state_q     <= ST_IDLE;
        brk_q       <= 1'b0;
        ext_q       <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (fall) begin
            if (!ps2_data_s) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= 3'd0;
              par_err_q <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          ST_DATA: if (fall) begin
            shift_q   <= {ps2_data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: if (fall) begin
            par_err_q <= ~(^{shift_q, ps2_data_s});
            state_q   <= ST_STOP;
          end
          ST_STOP: if (fall) begin
            if (ps2_data_s && !par_err_q) begin
              state_q <= ST_PROCESS;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          ST_PROCESS: begin
            state_q <= ST_IDLE;
            if (shift_q == SC_BREAK) begin
              brk_q <= 1'b1;
            end else if (shift_q == SC_EXT) begin
              ext_q <= 1'b1;
            end else begin
              brk_q <= 1'b0;
              ext_q <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
              if (lk.hit && !brk_q && !ext_q) held_q[lk.key] <= 1'b1;
              else if (lk.hit && brk_q)       held_q[lk.key] <= 1'b0;
`endif
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push_i    (push),
    .data_i    (lk.key),
    .pop_i     (key_ready),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (key_code),
    .overflow_o(overflow)
  );

  assign key_valid   = !fifo_empty;
  assign frame_err   = frame_err_q;
  assign dbg_state_o = state_q;

  // Full is implied by the FIFO's own drop logic; kept for binding checkers.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
